// File: rtl/data_rport.sv
// Data-side read responder: serves pipeline word reads from a one-entry snooped
// buffer or over an AXI4-Lite read channel, stalling the pipeline while the bus is busy.
module data_rport #(
  parameter bit BUF_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        DATA_RDEN,
  input  logic [31:0] DATA_RIADDR,
  output logic [31:0] DATA_ROADDR,
  output logic        DATA_RVALID,
  output logic [31:0] DATA_RDATA,
  output logic        DATA_RERR,
  output logic        MEM_WAIT,
  input  logic        SNOOP_W_EN,
  input  logic [31:0] SNOOP_W_ADDR,
  output logic        M_ARVALID,
  input  logic        M_ARREADY,
  output logic [31:0] M_ARADDR,
  input  logic        M_RVALID,
  output logic        M_RREADY,
  input  logic [31:0] M_RDATA,
  input  logic [1:0]  M_RRESP
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic        flush_pend_q, flush_pend_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;
  logic        buf_vld_q, buf_vld_d;
  logic [29:0] buf_tag_q, buf_tag_d;
  logic [31:0] buf_data_q, buf_data_d;

  logic accept, buf_hit, beat, fill, snoop_fill, snoop_buf;
  logic unused_snoop_lsb;

  assign unused_snoop_lsb = ^SNOOP_W_ADDR[1:0];

  assign accept  = (state_q == S_IDLE || state_q == S_RESP) && DATA_RDEN && !FLUSH;
  assign buf_hit = BUF_EN && buf_vld_q && (buf_tag_q == DATA_RIADDR[31:2]);
  // Every consumed R beat may fill the buffer, including beats of flushed reads.
  assign beat       = (state_q == S_DATA || state_q == S_DRAIN) && M_RVALID;
  assign fill       = beat && (M_RRESP == 2'b00);
  assign snoop_fill = SNOOP_W_EN && (SNOOP_W_ADDR[31:2] == araddr_q[31:2]);
  assign snoop_buf  = SNOOP_W_EN && (SNOOP_W_ADDR[31:2] == buf_tag_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      flush_pend_q <= 1'b0;
      req_addr_q   <= '0;
      araddr_q     <= '0;
      rdata_q      <= '0;
      rerr_q       <= 1'b0;
      buf_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      req_addr_q   <= req_addr_d;
      araddr_q     <= araddr_d;
      rdata_q      <= rdata_d;
      rerr_q       <= rerr_d;
      buf_vld_q    <= buf_vld_d;
    end
  end

  always_ff @(posedge CLK) begin
    buf_tag_q  <= buf_tag_d;
    buf_data_q <= buf_data_d;
  end

  // A flush seen while AR is still pending is remembered until the handshake completes.
  assign flush_pend_d = (state_q == S_ADDR) && !M_ARREADY && (FLUSH || flush_pend_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) state_d = buf_hit ? S_RESP : S_ADDR;
        else        state_d = S_IDLE;
      end
      S_ADDR: begin
        if (M_ARREADY) state_d = (FLUSH || flush_pend_q) ? S_DRAIN : S_DATA;
      end
      S_DATA: begin
        if (FLUSH)         state_d = M_RVALID ? S_IDLE : S_DRAIN;
        else if (M_RVALID) state_d = S_RESP;
      end
      S_DRAIN: begin
        if (M_RVALID) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_addr_d = req_addr_q;
    araddr_d   = araddr_q;
    rdata_d    = rdata_q;
    rerr_d     = rerr_q;
    if (accept) begin
      req_addr_d = DATA_RIADDR;
      if (buf_hit) begin
        rdata_d = buf_data_q;
        rerr_d  = 1'b0;
      end else begin
        araddr_d = {DATA_RIADDR[31:2], 2'b00};
      end
    end
    if (state_q == S_DATA && M_RVALID && !FLUSH) begin
      rerr_d  = (M_RRESP != 2'b00);
      rdata_d = (M_RRESP != 2'b00) ? 32'h0 : M_RDATA;
    end
  end

  // A snoop to the word being filled wins over the fill.
  always_comb begin
    buf_vld_d  = buf_vld_q;
    buf_tag_d  = buf_tag_q;
    buf_data_d = buf_data_q;
    if (fill) begin
      buf_vld_d  = !snoop_fill;
      buf_tag_d  = araddr_q[31:2];
      buf_data_d = M_RDATA;
    end else if (snoop_buf) begin
      buf_vld_d = 1'b0;
    end
  end

  always_comb begin
    DATA_RVALID = (state_q == S_RESP) && !FLUSH;
    DATA_RERR   = (state_q == S_RESP) && !FLUSH && rerr_q;
    DATA_RDATA  = rdata_q;
    DATA_ROADDR = req_addr_q;
    MEM_WAIT    = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_DRAIN);
    M_ARVALID   = (state_q == S_ADDR);
    M_ARADDR    = araddr_q;
    M_RREADY    = (state_q == S_DATA) || (state_q == S_DRAIN);
  end

endmodule

// File: tb/tb_data_rport.sv
// Bench for data_rport: directed reads against an AXI slave model, with a
// transaction-level buffer model and response scoreboard checked every cycle.
module tb_data_rport;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        rst_nb = 1'b1;
  logic        FLUSH, DATA_RDEN, SNOOP_W_EN;
  logic [31:0] DATA_RIADDR, SNOOP_W_ADDR;
  logic [31:0] DATA_ROADDR, DATA_RDATA, M_ARADDR;
  logic        DATA_RVALID, DATA_RERR, MEM_WAIT, M_ARVALID, M_RREADY;
  logic        M_ARREADY, M_RVALID;
  logic [31:0] M_RDATA;
  logic [1:0]  M_RRESP;

  logic [31:0] nb_unused_roaddr, nb_unused_rdata, nb_unused_araddr;
  logic        nb_unused_rvalid, nb_unused_rerr, nb_unused_mw, nb_ARVALID, nb_unused_rready;

  always #5 CLK = ~CLK;

  data_rport #(.BUF_EN(1'b1)) u_dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR),
    .DATA_ROADDR(DATA_ROADDR), .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
    .DATA_RERR(DATA_RERR), .MEM_WAIT(MEM_WAIT), .SNOOP_W_EN(SNOOP_W_EN),
    .SNOOP_W_ADDR(SNOOP_W_ADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_ARADDR(M_ARADDR), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA),
    .M_RRESP(M_RRESP));

  data_rport #(.BUF_EN(1'b0)) u_nb (
    .CLK(CLK), .RST(rst_nb), .FLUSH(FLUSH), .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR),
    .DATA_ROADDR(nb_unused_roaddr), .DATA_RVALID(nb_unused_rvalid), .DATA_RDATA(nb_unused_rdata),
    .DATA_RERR(nb_unused_rerr), .MEM_WAIT(nb_unused_mw), .SNOOP_W_EN(SNOOP_W_EN),
    .SNOOP_W_ADDR(SNOOP_W_ADDR), .M_ARVALID(nb_ARVALID), .M_ARREADY(M_ARREADY),
    .M_ARADDR(nb_unused_araddr), .M_RVALID(M_RVALID), .M_RREADY(nb_unused_rready),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t       expq[$];
  resp_t       cr;
  int          checks = 0;
  int          failures = 0;

  // Reference model: buffer contents and what the bus is expected to be asked for.
  logic        m_vld = 1'b0;
  logic [29:0] m_tag = '0;
  logic [31:0] m_data = '0;
  logic        exp_bus = 1'b0;
  logic [31:0] exp_araddr = '0;

  // Slave configuration and state.
  logic [31:0] sl_data = '0;
  logic [1:0]  sl_resp = '0;
  int          sl_ad = 0, sl_rd = 0, acnt = 0, rcnt = 0;
  logic        rd_pend = 1'b0, ar_hs, r_hs;
  logic        arv_n = 1'b0, rr_n = 1'b0;

  // Observations of the last do_read.
  int          ob_lat, ob_mw;
  logic        ob_ar1, ob_nbar1, ob_err;
  logic [31:0] ob_araddr1, ob_data, ob_roaddr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    arv_n <= M_ARVALID;
    rr_n  <= M_RREADY;
  end

  initial begin
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = '0;
    forever begin
      @(posedge CLK); #1;
      if (RST) begin
        M_ARREADY = 1'b0; M_RVALID = 1'b0; rd_pend = 1'b0; acnt = 0; rcnt = 0;
      end else begin
        ar_hs = arv_n && M_ARREADY;
        r_hs  = rr_n && M_RVALID;
        if (ar_hs) begin M_ARREADY = 1'b0; rd_pend = 1'b1; rcnt = 0; acnt = 0; end
        if (r_hs) begin M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = '0; end
        if (M_ARVALID && !M_ARREADY && !rd_pend) begin
          if (acnt >= sl_ad) M_ARREADY = 1'b1;
          else acnt++;
        end
        if (rd_pend && !M_RVALID) begin
          if (rcnt >= sl_rd) begin
            M_RVALID = 1'b1; M_RDATA = sl_data; M_RRESP = sl_resp; rd_pend = 1'b0;
          end else rcnt++;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      if (DATA_RVALID) begin
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rvalid actual=1 required=0 roaddr=%h", DATA_ROADDR);
        end else begin
          cr = expq.pop_front();
          chk("roaddr", DATA_ROADDR, cr.addr);
          chk("rdata", DATA_RDATA, cr.data);
          chk("rerr", DATA_RERR, cr.err);
        end
        chk("mw_in_resp", MEM_WAIT, 0);
      end else begin
        chk("rerr_without_rvalid", DATA_RERR, 0);
      end
      if (!exp_bus) chk("unexpected_ar", M_ARVALID, 0);
      else if (M_ARVALID) chk("araddr", M_ARADDR, exp_araddr);
    end
  end

  task automatic snoop(input logic [31:0] a);
    SNOOP_W_EN = 1'b1; SNOOP_W_ADDR = a;
    if (m_vld && m_tag == a[31:2]) m_vld = 1'b0;
    @(posedge CLK); #1;
    SNOOP_W_EN = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] sdata, input logic [1:0] sresp,
                         input int ad, input int rd, input int snp_cyc, input logic [31:0] snp_addr,
                         input int fl_cyc);
    logic  hit;
    resp_t r;
    bit    done;
    sl_data = sdata; sl_resp = sresp; sl_ad = ad; sl_rd = rd;
    hit = m_vld && (m_tag == addr[31:2]);
    r.addr = addr;
    if (hit) begin
      exp_bus = 1'b0; r.data = m_data; r.err = 1'b0;
    end else begin
      exp_bus = 1'b1; exp_araddr = {addr[31:2], 2'b00};
      r.data = (sresp == 2'b00) ? sdata : 32'h0;
      r.err  = (sresp != 2'b00);
      if (sresp == 2'b00) begin m_vld = 1'b1; m_tag = addr[31:2]; m_data = sdata; end
    end
    if (snp_cyc >= 0 && snp_addr[31:2] == addr[31:2]) m_vld = 1'b0;
    if (fl_cyc < 0) expq.push_back(r);
    ob_lat = -1; ob_mw = 0; ob_ar1 = 1'b0; ob_nbar1 = 1'b0; ob_araddr1 = '0;
    ob_data = '0; ob_err = 1'b0; ob_roaddr = '0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      DATA_RDEN = (c == 0); DATA_RIADDR = addr;
      SNOOP_W_EN = (c == snp_cyc); SNOOP_W_ADDR = snp_addr;
      FLUSH = (c == fl_cyc);
      @(negedge CLK);
      if (c == 1) begin ob_ar1 = M_ARVALID; ob_araddr1 = M_ARADDR; ob_nbar1 = nb_ARVALID; end
      if (c >= 1 && MEM_WAIT) ob_mw++;
      if (c >= 1 && DATA_RVALID && ob_lat < 0) begin
        ob_lat = c; ob_data = DATA_RDATA; ob_err = DATA_RERR; ob_roaddr = DATA_ROADDR;
      end
      if (c >= 1 && !MEM_WAIT && (ob_lat >= 0 || fl_cyc >= 0)) done = 1'b1;
      @(posedge CLK); #1;
    end
    DATA_RDEN = 1'b0; SNOOP_W_EN = 1'b0; FLUSH = 1'b0;
    chk("read_completes", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    FLUSH = 1'b0; DATA_RDEN = 1'b0; SNOOP_W_EN = 1'b0; DATA_RIADDR = '0; SNOOP_W_ADDR = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rvalid", DATA_RVALID, 0);  chk("rst_rdata", DATA_RDATA, 0);
    chk("rst_roaddr", DATA_ROADDR, 0);  chk("rst_rerr", DATA_RERR, 0);
    chk("rst_memwait", MEM_WAIT, 0);    chk("rst_arvalid", M_ARVALID, 0);
    chk("rst_araddr", M_ARADDR, 0);     chk("rst_rready", M_RREADY, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // Cold miss
    do_read(32'h0000_1006, 32'hDEAD_BEEF, 2'b00, 0, 0, -1, 32'h0, -1);
    chk("cold_lat", ob_lat, 3);           chk("cold_mw", ob_mw, 2);
    chk("cold_ar1", ob_ar1, 1);           chk("cold_araddr", ob_araddr1, 32'h0000_1004);
    chk("cold_data", ob_data, 32'hDEAD_BEEF); chk("cold_roaddr", ob_roaddr, 32'h0000_1006);

    // Hit, then three back-to-back hits
    do_read(32'h0000_1004, 32'h0, 2'b00, 0, 0, -1, 32'h0, -1);
    chk("hit_lat", ob_lat, 1); chk("hit_mw", ob_mw, 0); chk("hit_ar1", ob_ar1, 0);
    chk("hit_data", ob_data, 32'hDEAD_BEEF);
    exp_bus = 1'b0;
    expq.push_back('{32'h0000_1004, 32'hDEAD_BEEF, 1'b0});
    expq.push_back('{32'h0000_1005, 32'hDEAD_BEEF, 1'b0});
    expq.push_back('{32'h0000_1007, 32'hDEAD_BEEF, 1'b0});
    for (int c = 0; c < 4; c++) begin
      DATA_RDEN = (c < 3);
      DATA_RIADDR = (c == 0) ? 32'h0000_1004 : (c == 1) ? 32'h0000_1005 : 32'h0000_1007;
      @(negedge CLK);
      if (c >= 1) begin chk("b2b_rvalid", DATA_RVALID, 1); chk("b2b_mw", MEM_WAIT, 0); end
      @(posedge CLK); #1;
    end
    DATA_RDEN = 1'b0;

    // Snoop invalidates, snoop coincident with fill drops it, snoop with hit returns old data
    snoop(32'h0000_1005);
    do_read(32'h0000_1004, 32'hCAFE_F00D, 2'b00, 0, 0, -1, 32'h0, -1);
    chk("snoop_miss_lat", ob_lat, 3); chk("snoop_miss_data", ob_data, 32'hCAFE_F00D);
    snoop(32'h0000_1004);
    do_read(32'h0000_1004, 32'h1111_2222, 2'b00, 0, 0, 2, 32'h0000_1006, -1);
    chk("snoopfill_lat", ob_lat, 3); chk("snoopfill_data", ob_data, 32'h1111_2222);
    do_read(32'h0000_1004, 32'h3333_4444, 2'b00, 0, 0, -1, 32'h0, -1);
    chk("after_snoopfill_lat", ob_lat, 3);
    do_read(32'h0000_1004, 32'h0, 2'b00, 0, 0, 0, 32'h0000_1004, -1);
    chk("snoophit_lat", ob_lat, 1); chk("snoophit_data", ob_data, 32'h3333_4444);
    do_read(32'h0000_1004, 32'h5555_6666, 2'b00, 0, 0, -1, 32'h0, -1);
    chk("after_snoophit_lat", ob_lat, 3);

    // Bus error
    do_read(32'h0000_3000, 32'h1234_5678, 2'b10, 0, 0, -1, 32'h0, -1);
    chk("err_lat", ob_lat, 3); chk("err_flag", ob_err, 1); chk("err_data", ob_data, 32'h0);
    do_read(32'h0000_3000, 32'h0BAD_F00D, 2'b00, 0, 0, -1, 32'h0, -1);
    chk("after_err_lat", ob_lat, 3);

    // Flush during ADDR with a slow slave
    do_read(32'h0000_4000, 32'h4444_0000, 2'b00, 3, 2, -1, 32'h0, 1);
    chk("flush_no_resp", ob_lat, 32'hFFFF_FFFF); chk("flush_mw", ob_mw, 7);
    do_read(32'h0000_4000, 32'h0, 2'b00, 0, 0, -1, 32'h0, -1);
    chk("drain_fill_lat", ob_lat, 1); chk("drain_fill_data", ob_data, 32'h4444_0000);

    // Asynchronous reset while in DATA
    sl_data = 32'h5555_0000; sl_resp = 2'b00; sl_ad = 0; sl_rd = 6;
    exp_bus = 1'b1; exp_araddr = 32'h0000_5000;
    DATA_RIADDR = 32'h0000_5000; DATA_RDEN = 1'b1;
    @(posedge CLK); #1; DATA_RDEN = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    @(negedge CLK);
    chk("pre_rst_rready", M_RREADY, 1);
    #2; RST = 1'b1; expq.delete(); m_vld = 1'b0;
    #1;
    chk("arst_rvalid", DATA_RVALID, 0);  chk("arst_rdata", DATA_RDATA, 0);
    chk("arst_roaddr", DATA_ROADDR, 0);  chk("arst_rerr", DATA_RERR, 0);
    chk("arst_memwait", MEM_WAIT, 0);    chk("arst_arvalid", M_ARVALID, 0);
    chk("arst_araddr", M_ARADDR, 0);     chk("arst_rready", M_RREADY, 0);
    @(posedge CLK); #2; RST = 1'b0; rst_nb = 1'b0;
    @(posedge CLK); #1;

    do_read(32'h0000_4000, 32'h7777_8888, 2'b00, 0, 0, -1, 32'h0, -1);
    chk("post_rst_miss_lat", ob_lat, 3); chk("nobuf_miss1", ob_nbar1, 1);
    do_read(32'h0000_4000, 32'h0, 2'b00, 0, 0, -1, 32'h0, -1);
    chk("post_rst_hit_lat", ob_lat, 1); chk("post_rst_hit_ar", ob_ar1, 0);
    chk("nobuf_miss2", ob_nbar1, 1);

    repeat (2) @(posedge CLK);
    chk("all_responses_seen", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
